// File: rtl/image_pkg.sv
// Shared image-receive definitions: top-level FSM state codes, rx FSM encoding, default frame size.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package image_pkg;

  // Top-level FSM state codes, shared with the command/state FSM
  localparam logic [7:0] ST_WAIT      = 8'h01;
  localparam logic [7:0] ST_TRANSPORT = 8'h02;
  localparam logic [7:0] ST_DISPLAY   = 8'h03;

  // Default frame geometry
  localparam int IMG_W_DEF = 128;
  localparam int IMG_H_DEF = 128;

  // Receive sequencer states; RX_CHK is only reachable with the checksum build
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_ARMED = 3'd1,
    RX_HI    = 3'd2,
    RX_LO    = 3'd3,
    RX_CHK   = 3'd4,
    RX_DONE  = 3'd5,
    RX_ERR   = 3'd6
  } rx_state_e;

  // States in which a frame is partially received and the idle timer runs
  function automatic logic rx_is_active(input rx_state_e s);
    return (s == RX_HI) || (s == RX_LO) || (s == RX_CHK);
  endfunction

endpackage

// File: rtl/rx_timeout_cnt.sv
// Inter-byte idle timer: flags expiry after TIMEOUT_CYC consecutive enabled, uncleared clocks.
// Latency: expired is combinational from the count register, high on the TIMEOUT_CYC-th idle clock.
// Backpressure: none; the counter saturates at expiry until cleared.
module rx_timeout_cnt #(
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int              CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count enabled idle clocks; a clear always wins and a full count holds
  always_comb begin
    cnt_d   = cnt_q;
    expired = en && !clr && (cnt_q == LAST);
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/image_rx_ctrl.sv
// Pairs UART bytes into RGB565 pixels and writes them linearly into the frame buffer during TRANSPORT.
// Latency: 1 clock from i_rx_done to o_wr_en; all outputs registered. Macro IMAGE_RX_CHECKSUM_EN adds a trailing sum byte check.
// Backpressure: none; bytes arrive as strobes and each completed pixel is written on the following clock.
module image_rx_ctrl
  import image_pkg::*;
#(
  parameter int IMG_W       = IMG_W_DEF,
  parameter int IMG_H       = IMG_H_DEF,
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic              i_clk_sys,
  input  logic              i_rst,
  input  logic [7:0]        i_state,
  input  logic [7:0]        i_data,
  input  logic              i_rx_done,
  output logic              o_image_receiving,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data,
  output logic              o_frame_done,
  output logic              o_err_timeout,
  output logic              o_err_chk
);

  localparam int                NPIX     = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

  rx_state_e         state_q, state_d;
  logic              recv_q, recv_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
  logic              err_tmo_q, err_tmo_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
`ifdef IMAGE_RX_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              err_chk_q, err_chk_d;
`endif

  logic abort;
  logic last_pix;
  logic tmo_en;
  logic tmo_clr;
  logic tmo_expired;

  // Leaving TRANSPORT cancels any frame in progress, whatever else happens this cycle
  assign abort    = (state_q != RX_IDLE) && (i_state != ST_TRANSPORT);
  assign last_pix = (pix_q == LAST_PIX);
  assign tmo_en   = rx_is_active(state_q);
  assign tmo_clr  = i_rx_done || !tmo_en;

  rx_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (i_clk_sys),
    .rst     (i_rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // State register
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: abort first, then timeout, then byte arrival
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = RX_IDLE;
    end else begin
      case (state_q)
        RX_IDLE:  if (i_state == ST_TRANSPORT) state_d = RX_ARMED;
        RX_ARMED: if (i_rx_done) state_d = RX_LO;
        RX_HI: begin
          if (tmo_expired)    state_d = RX_ERR;
          else if (i_rx_done) state_d = RX_LO;
        end
        RX_LO: begin
          if (tmo_expired) begin
            state_d = RX_ERR;
          end else if (i_rx_done) begin
`ifdef IMAGE_RX_CHECKSUM_EN
            state_d = last_pix ? RX_CHK : RX_HI;
`else
            state_d = last_pix ? RX_DONE : RX_HI;
`endif
          end
        end
`ifdef IMAGE_RX_CHECKSUM_EN
        RX_CHK: begin
          if (tmo_expired)    state_d = RX_ERR;
          else if (i_rx_done) state_d = RX_DONE;
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // Output and datapath next values; address/data hold between writes
  always_comb begin
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    err_tmo_d    = 1'b0;
    hi_d         = hi_q;
    pix_d        = pix_q;
`ifdef IMAGE_RX_CHECKSUM_EN
    sum_d        = sum_q;
    err_chk_d    = 1'b0;
`endif
    if (state_q == RX_IDLE) begin
      if (i_state == ST_TRANSPORT) begin
        pix_d = '0;
`ifdef IMAGE_RX_CHECKSUM_EN
        sum_d = '0;
`endif
      end
    end else if (!abort) begin
      case (state_q)
        RX_ARMED, RX_HI: begin
          if (state_q == RX_HI && tmo_expired) begin
            err_tmo_d = 1'b1;
          end else if (i_rx_done) begin
            hi_d = i_data;
`ifdef IMAGE_RX_CHECKSUM_EN
            sum_d = sum_q + i_data;
`endif
          end
        end
        RX_LO: begin
          if (tmo_expired) begin
            err_tmo_d = 1'b1;
          end else if (i_rx_done) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pix_q;
            wr_data_d = {hi_q, i_data};
`ifdef IMAGE_RX_CHECKSUM_EN
            sum_d = sum_q + i_data;
`endif
            if (last_pix) begin
`ifndef IMAGE_RX_CHECKSUM_EN
              frame_done_d = 1'b1;
`endif
            end else begin
              pix_d = pix_q + 1'b1;
            end
          end
        end
`ifdef IMAGE_RX_CHECKSUM_EN
        RX_CHK: begin
          if (tmo_expired) begin
            err_tmo_d = 1'b1;
          end else if (i_rx_done) begin
            if (i_data == sum_q) frame_done_d = 1'b1;
            else                 err_chk_d    = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
    recv_d = rx_is_active(state_d);
  end

  // Registered outputs and datapath
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      recv_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      err_tmo_q    <= 1'b0;
      hi_q         <= '0;
      pix_q        <= '0;
`ifdef IMAGE_RX_CHECKSUM_EN
      sum_q        <= '0;
      err_chk_q    <= 1'b0;
`endif
    end else begin
      recv_q       <= recv_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      err_tmo_q    <= err_tmo_d;
      hi_q         <= hi_d;
      pix_q        <= pix_d;
`ifdef IMAGE_RX_CHECKSUM_EN
      sum_q        <= sum_d;
      err_chk_q    <= err_chk_d;
`endif
    end
  end

  assign o_image_receiving = recv_q;
  assign o_wr_en           = wr_en_q;
  assign o_wr_addr         = wr_addr_q;
  assign o_wr_data         = wr_data_q;
  assign o_frame_done      = frame_done_q;
  assign o_err_timeout     = err_tmo_q;
`ifdef IMAGE_RX_CHECKSUM_EN
  assign o_err_chk         = err_chk_q;
`else
  assign o_err_chk         = 1'b0;
`endif

endmodule
